carregainstrucao: RTL and testbench

Serial instruction loader: the write side of the instruction memory that the fetch stage reads. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instructions, and issues one write per instruction into the instruction memory's write port at consecutive addresses from 0. Sits between the board's byte source (UART receiver or test harness) and the instruction memory. Raises a completion flag so the processor can be released from reset.

---
 rtl/carregainstrucao.sv | 157 +++++++++++++++
 tb/tb_carregainstrucao.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/carregainstrucao.sv
// Byte-serial instruction loader: assembles little-endian 32-bit words and writes them to
// consecutive instruction-memory addresses. Define CARREGA_CHECKSUM_EN for a trailing XOR byte check.
module carregainstrucao #(
    parameter int unsigned NUM_INSTR = 16,
    parameter int unsigned ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iniciar,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              carregando,
    output logic              pronto,
    output logic              erro
);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_INSTR - 1);

    typedef enum logic [2:0] {
        StOcioso,
        StRecebe,
        StEscreve,
`ifdef CARREGA_CHECKSUM_EN
        StCheca,
`endif
        StFim
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              carregando_q, carregando_d;
    logic              pronto_q, pronto_d;
    logic              accept;
`ifdef CARREGA_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    logic              erro_q, erro_d;
`endif

    assign accept = byte_valid && byte_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        word_d  = word_q;
`ifdef CARREGA_CHECKSUM_EN
        csum_d  = csum_q;
        erro_d  = erro_q;
`endif
        case (state_q)
            StOcioso, StFim: begin
                if (iniciar) begin
                    state_d = StRecebe;
                    cnt_d   = 2'd0;
                    addr_d  = '0;
`ifdef CARREGA_CHECKSUM_EN
                    csum_d  = 8'd0;
                    erro_d  = 1'b0;
`endif
                end
            end
            StRecebe: begin
                if (accept) begin
                    word_d[8*cnt_q +: 8] = byte_in;
                    cnt_d = cnt_q + 2'd1;
`ifdef CARREGA_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (cnt_q == 2'd3) begin
                        state_d = StEscreve;
                    end
                end
            end
            StEscreve: begin
                // Address saturates at the last word; the session ends there.
                if (addr_q != LastAddr) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = StRecebe;
                end else begin
`ifdef CARREGA_CHECKSUM_EN
                    state_d = StCheca;
`else
                    state_d = StFim;
`endif
                end
            end
`ifdef CARREGA_CHECKSUM_EN
            StCheca: begin
                if (accept) begin
                    erro_d  = (byte_in != csum_q);
                    state_d = StFim;
                end
            end
`endif
            default: state_d = StOcioso;
        endcase

        // Outputs are registered from the next state so they align with state_q.
        byte_ready_d = (state_d == StRecebe);
`ifdef CARREGA_CHECKSUM_EN
        byte_ready_d = byte_ready_d || (state_d == StCheca);
`endif
        mem_we_d     = (state_d == StEscreve);
        carregando_d = (state_d != StOcioso) && (state_d != StFim);
        pronto_d     = (state_d == StFim);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StOcioso;
            cnt_q        <= 2'd0;
            addr_q       <= '0;
            word_q       <= 32'd0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            carregando_q <= 1'b0;
            pronto_q     <= 1'b0;
`ifdef CARREGA_CHECKSUM_EN
            csum_q       <= 8'd0;
            erro_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            word_q       <= word_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            carregando_q <= carregando_d;
            pronto_q     <= pronto_d;
`ifdef CARREGA_CHECKSUM_EN
            csum_q       <= csum_d;
            erro_q       <= erro_d;
`endif
        end
    end

    assign byte_ready = byte_ready_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = word_q;
    assign carregando = carregando_q;
    assign pronto     = pronto_q;
`ifdef CARREGA_CHECKSUM_EN
    assign erro       = erro_q;
`else
    assign erro       = 1'b0;
`endif

endmodule

// File: tb/tb_carregainstrucao.sv
// Self-checking bench for carregainstrucao: vector table, random full loads against a
// word-list model, and hand-written reset / iniciar corner sequences.
module tb_carregainstrucao;
    localparam int NUM = 16;
    localparam int AW  = 4;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          iniciar    = 1'b0;
    logic [7:0]    byte_in    = 8'd0;
    logic          byte_valid = 1'b0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          carregando;
    logic          pronto;
    logic          erro;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic          prev_we = 1'b0;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[5];

    carregainstrucao #(
        .NUM_INSTR(NUM),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .iniciar   (iniciar),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .carregando(carregando),
        .pronto    (pronto),
        .erro      (erro)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: records every write and checks the enable is a single-cycle pulse.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            check("we single-cycle", {31'd0, prev_we}, 32'd0);
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_data);
        end
        prev_we = (mem_we === 1'b1);
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("byte_ready timeout", 32'd0, 32'd1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic pulse_iniciar(input string name);
        check({name, " ready before"}, {31'd0, byte_ready}, 32'd0);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        check({name, " ready+1"}, {29'd0, byte_ready, carregando, pronto}, 32'b110);
        check({name, " erro clr"}, {31'd0, erro}, 32'd0);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check({name, " async data"}, mem_data, 32'd0);
        check({name, " async ctrl"}, {23'd0, byte_ready, mem_we, carregando, pronto, erro, mem_addr},
              32'd0);
        @(negedge clk);
        rst = 1'b1;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic wait_writes(input string name, input int n);
        int t = 0;
        #1;
        while (wr_data.size() < n && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        check({name, " write count"}, wr_data.size(), n);
    endtask

    // Random full session; model is the byte list regrouped into little-endian words.
    task automatic full_load(input string name, input int gap, input logic [7:0] flip);
        logic [7:0]  bytes[4*NUM];
        logic [31:0] exp_w[NUM];
        logic [7:0]  x;
        x = 8'd0;
        for (int i = 0; i < 4 * NUM; i++) begin
            bytes[i] = 8'($urandom);
            x ^= bytes[i];
        end
        for (int i = 0; i < NUM; i++) begin
            exp_w[i] = {bytes[4*i+3], bytes[4*i+2], bytes[4*i+1], bytes[4*i]};
        end
        pulse_iniciar(name);
        for (int i = 0; i < 4 * NUM; i++) begin
            repeat (gap) @(negedge clk);
            send_byte(bytes[i]);
        end
`ifdef CARREGA_CHECKSUM_EN
        check({name, " not done before csum"}, {31'd0, pronto}, 32'd0);
        send_byte(x ^ flip);
        check({name, " pronto"}, {31'd0, pronto}, 32'd1);
        check({name, " erro"}, {31'd0, erro}, {31'd0, (flip != 8'd0)});
`else
        @(negedge clk);
        check({name, " pronto W+1"}, {30'd0, pronto, carregando}, 32'b10);
        check({name, " erro tied"}, {31'd0, erro}, 32'd0);
`endif
        check({name, " ready idle"}, {31'd0, byte_ready}, 32'd0);
        wait_writes(name, NUM);
        for (int i = 0; i < NUM && i < wr_data.size(); i++) begin
            check({name, " addr"}, {28'd0, wr_addr[i]}, i);
            check({name, " data"}, wr_data[i], exp_w[i]);
        end
        repeat (6) @(negedge clk);
        #1;
        check({name, " no extra write"}, wr_data.size(), NUM);
        check({name, " pronto held"}, {31'd0, pronto}, 32'd1);
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h13, 8'h01, 8'h70, 8'h00, 32'h0070_0113};
        vecs[1] = '{8'hff, 8'h00, 8'hff, 8'h00, 32'h00ff_00ff};
        vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
        vecs[3] = '{8'hef, 8'hbe, 8'had, 8'hde, 32'hdead_beef};
        vecs[4] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h0403_0201};

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("init data", mem_data, 32'd0);
        check("init ctrl", {23'd0, byte_ready, mem_we, carregando, pronto, erro, mem_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table: one word each, back-to-back bytes, write at N+1, ready again at N+2.
        for (int v = 0; v < 5; v++) begin
            pulse_iniciar("vec");
            send_byte(vecs[v].b0);
            send_byte(vecs[v].b1);
            send_byte(vecs[v].b2);
            send_byte(vecs[v].b3);
            check("vec we", {31'd0, mem_we}, 32'd1);
            check("vec addr", {28'd0, mem_addr}, 32'd0);
            check("vec data", mem_data, vecs[v].word);
            check("vec ready in write", {31'd0, byte_ready}, 32'd0);
            @(negedge clk);
            check("vec we drop", {31'd0, mem_we}, 32'd0);
            check("vec ready again", {31'd0, byte_ready}, 32'd1);
            check("vec next addr", {28'd0, mem_addr}, 32'd1);
            do_reset("vec rst");
        end

        // iniciar during RECEBE must not disturb the byte or address counters.
        pulse_iniciar("ign");
        send_byte(8'h11);
        send_byte(8'h22);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        check("ign ready", {30'd0, byte_ready, mem_we}, 32'b10);
        send_byte(8'h33);
        send_byte(8'h44);
        check("ign we", {31'd0, mem_we}, 32'd1);
        check("ign addr0", {28'd0, mem_addr}, 32'd0);
        check("ign data0", mem_data, 32'h4433_2211);
        @(negedge clk);
        iniciar = 1'b1;
        send_byte(8'haa);
        iniciar = 1'b0;
        send_byte(8'hbb);
        send_byte(8'hcc);
        send_byte(8'hdd);
        check("ign addr1", {28'd0, mem_addr}, 32'd1);
        check("ign data1", mem_data, 32'hddcc_bbaa);
        do_reset("ign rst");

        // Full random loads, then a restart from FIM.
        full_load("load toggle", 1, 8'h00);
        pulse_iniciar("restart");
        send_byte(8'h5a);
        send_byte(8'h6b);
        send_byte(8'h7c);
        send_byte(8'h8d);
        check("restart addr", {28'd0, mem_addr}, 32'd0);
        check("restart data", mem_data, 32'h8d7c_6b5a);
        do_reset("restart rst");

        // Reset after two bytes of word 5: word 5 is never written.
        pulse_iniciar("abort");
        for (int i = 0; i < 22; i++) send_byte(8'($urandom));
        check("abort writes", wr_data.size(), 5);
        do_reset("abort rst");
        repeat (3) @(negedge clk);
        check("abort idle", {29'd0, byte_ready, pronto, mem_we}, 32'd0);
        pulse_iniciar("abort restart");
        send_byte(8'h13);
        send_byte(8'h01);
        send_byte(8'h70);
        send_byte(8'h00);
        check("abort restart addr", {28'd0, mem_addr}, 32'd0);
        check("abort restart data", mem_data, 32'h0070_0113);
        do_reset("abort rst2");

`ifdef CARREGA_CHECKSUM_EN
        full_load("csum ok", 0, 8'h00);
        pulse_iniciar("csum ok clr");
        do_reset("csum rst1");
        full_load("csum bad", 0, 8'h01);
        pulse_iniciar("csum bad clr");
        check("csum bad clr pronto", {31'd0, pronto}, 32'd0);
        do_reset("csum rst2");
`else
        full_load("load b2b", 0, 8'h00);
        do_reset("b2b rst");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
